data_mem_responder: RTL and testbench



---
 rtl/data_mem_responder_pkg.sv | 21 ++
 rtl/data_mem_responder_dmem_array.sv | 43 ++++
 rtl/data_mem_responder.sv | 129 ++++++++++++
 tb/tb_data_mem_responder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder.
//   state_e  : responder FSM states
//   WORD_W   : data word width
//   addr_err : true for a misaligned or out-of-range byte address
package data_mem_responder_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // The word index is zero-extended so that it is compared against the
  // full depth, not truncated to the array index width.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth_words);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth_words);
  endfunction

endpackage

// File: rtl/data_mem_responder_dmem_array.sv
// Single-port synchronous word array with a registered read port.
//   clk_i, rst_ni : clock, async active-low reset (read register only)
//   we_i, re_i    : write enable / read enable for the addressed word
//   addr_i        : word index
//   wdata_i       : write data
//   rdata_o       : read register, updated only when re_i is high
module dmem_array
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           we_i,
  input  logic                           re_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
  input  logic [WORD_W-1:0]              wdata_i,
  output logic [WORD_W-1:0]              rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
  logic [WORD_W-1:0] rdata_q;

  // Storage is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Holding the read register when re_i is low keeps load data stable
  // for as long as the response is stalled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits
// WAIT_CYCLES cycles, commits against the internal array and presents a
// response until the initiator takes it.
//   clk_i, rst_ni                          : clock, async active-low reset
//   req_valid_i/req_ready_o                : request handshake (ready only in IDLE)
//   req_write_i, req_addr_i, req_wdata_i   : request payload (byte address)
//   rsp_valid_o/rsp_ready_i                : response handshake
//   rsp_rdata_o, rsp_err_o                 : load data (0 for stores/errors), error flag
//   busy_o                                 : transaction in flight
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [31:0]       req_addr_i,
  input  logic [WORD_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [WORD_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              busy_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              write_q;
  logic [31:0]       addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic              rsp_err_q;
  logic              rd_hit_q;

  logic              accept;
  logic              commit;
  logic              c_write;
  logic [31:0]       c_addr;
  logic [WORD_W-1:0] c_wdata;
  logic              c_err;
  logic              arr_we;
  logic              arr_re;
  logic [WORD_W-1:0] arr_rdata;

  assign accept = (state_q == IDLE) && req_valid_i;

  // With no wait states the commit happens on the acceptance edge, so the
  // commit path must see the live request rather than the latched copy.
  assign commit  = (WAIT_CYCLES == 0) ? accept : ((state_q == WAIT) && (cnt_q == 4'd0));
  assign c_write = (state_q == IDLE) ? req_write_i : write_q;
  assign c_addr  = (state_q == IDLE) ? req_addr_i  : addr_q;
  assign c_wdata = (state_q == IDLE) ? req_wdata_i : wdata_q;
  assign c_err   = addr_err(c_addr, int'(DEPTH_WORDS));

  assign arr_we = commit &&  c_write && !c_err;
  assign arr_re = commit && !c_write && !c_err;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .we_i   (arr_we),
    .re_i   (arr_re),
    .addr_i (c_addr[AW+1:2]),
    .wdata_i(c_wdata),
    .rdata_o(arr_rdata)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rsp_err_q <= 1'b0;
      rd_hit_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            write_q <= req_write_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            if (WAIT_CYCLES == 0) begin
              state_q   <= RESP;
              rsp_err_q <= c_err;
              rd_hit_q  <= arr_re;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_LOAD;
            end
          end
        end
        WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q   <= RESP;
            rsp_err_q <= c_err;
            rd_hit_q  <= arr_re;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            state_q   <= IDLE;
            rsp_err_q <= 1'b0;
            rd_hit_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign busy_o      = (state_q != IDLE);
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = rd_hit_q ? arr_rdata : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_ready = 1'b0;
  bit          use0 = 1'b0;

  logic        rv2, rv0;
  logic        rr2, rr0, vv2, vv0, ee2, ee0, bb2, bb0;
  logic [31:0] dd2, dd0;
  logic        o_req_ready, o_rsp_valid, o_rsp_err, o_busy;
  logic [31:0] o_rsp_rdata;

  int checks = 0;
  int errs = 0;
  int cyc = 0;
  logic [31:0] mdl [int];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rv2 = req_valid & ~use0;
  assign rv0 = req_valid & use0;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(rv2), .req_ready_o(rr2),
    .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(vv2), .rsp_ready_i(rsp_ready), .rsp_rdata_o(dd2),
    .rsp_err_o(ee2), .busy_o(bb2)
  );

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(rv0), .req_ready_o(rr0),
    .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(vv0), .rsp_ready_i(rsp_ready), .rsp_rdata_o(dd0),
    .rsp_err_o(ee0), .busy_o(bb0)
  );

  assign o_req_ready = use0 ? rr0 : rr2;
  assign o_rsp_valid = use0 ? vv0 : vv2;
  assign o_rsp_err   = use0 ? ee0 : ee2;
  assign o_busy      = use0 ? bb0 : bb2;
  assign o_rsp_rdata = use0 ? dd0 : dd2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int key(input logic [31:0] a);
    return (use0 ? 32'h0010_0000 : 32'h0) + int'(a >> 2);
  endfunction

  // Caller is at a negedge; returns at the negedge after the response handshake.
  task automatic txn(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                     input int hold, input bit poke, output int acc_cyc);
    int n;
    int w;
    logic        exp_e;
    logic [31:0] exp_d;
    logic [31:0] s_d;
    logic        s_e;
    w = use0 ? 0 : 2;
    exp_e = (a % 4 != 0) || ((a / 4) >= DEPTH);
    exp_d = 32'h0;
    if (!exp_e && !wr) exp_d = mdl.exists(key(a)) ? mdl[key(a)] : 32'h0;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd;
    n = 0;
    while (!o_req_ready && n < 50) begin @(negedge clk); n++; end
    chk("accept_timeout", {31'd0, n >= 50}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    acc_cyc = cyc;
    req_valid = 1'b0;
    n = 1;
    while (!o_rsp_valid && n < 50) begin
      if (n == 1) chk("busy_in_wait", {31'd0, o_busy}, 32'd1);
      @(negedge clk);
      n++;
    end
    chk("latency", n, w + 1);
    chk("rsp_err", {31'd0, o_rsp_err}, {31'd0, exp_e});
    chk("rsp_rdata", o_rsp_rdata, exp_d);
    chk("busy_resp", {31'd0, o_busy}, 32'd1);
    chk("req_ready_resp", {31'd0, o_req_ready}, 32'd0);
    if (!exp_e && wr) mdl[key(a)] = wd;
    s_d = o_rsp_rdata;
    s_e = o_rsp_err;
    for (int i = 0; i < hold; i++) begin
      if (poke && i == 2) begin
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0; req_wdata = 32'hBAD0_BAD0;
      end
      @(negedge clk);
      req_valid = 1'b0;
      chk("hold_valid", {31'd0, o_rsp_valid}, 32'd1);
      chk("hold_rdata", o_rsp_rdata, s_d);
      chk("hold_err", {31'd0, o_rsp_err}, {31'd0, s_e});
      chk("hold_req_ready", {31'd0, o_req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("after_hs_valid", {31'd0, o_rsp_valid}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int a0, a1, a2;
    int widx [12];
    logic [31:0] a;
    for (int i = 0; i < 8; i++) widx[i] = i;
    for (int i = 0; i < 4; i++) widx[8 + i] = 252 + i;

    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      use0 = (s == 1);
      #1;
      chk("rst_req_ready", {31'd0, o_req_ready}, 32'd1);
      chk("rst_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
      chk("rst_busy", {31'd0, o_busy}, 32'd0);
      chk("rst_rsp_err", {31'd0, o_rsp_err}, 32'd0);
      chk("rst_rsp_rdata", o_rsp_rdata, 32'd0);
    end
    use0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed, three-cycle latency
    txn(1'b1, 32'h10, 32'hDEAD_BEEF, 0, 1'b0, acc);
    txn(1'b0, 32'h10, 32'h0, 0, 1'b0, acc);
    txn(1'b1, 32'h0, 32'h1111_1111, 0, 1'b0, acc);
    txn(1'b0, 32'h13, 32'h0, 0, 1'b0, acc);
    txn(1'b1, 32'h400, 32'hCAFE_F00D, 0, 1'b0, acc);
    txn(1'b0, 32'h0, 32'h0, 0, 1'b0, acc);
    txn(1'b1, 32'h3FC, 32'h5A5A_A5A5, 0, 1'b0, acc);
    txn(1'b0, 32'h3FC, 32'h0, 0, 1'b0, acc);
    txn(1'b0, 32'h10, 32'h0, 10, 1'b1, acc);
    txn(1'b0, 32'h0, 32'h0, 0, 1'b0, acc);

    // Zero wait states, back to back
    use0 = 1'b1;
    txn(1'b1, 32'h0, 32'hA0A0_0000, 0, 1'b0, a0);
    txn(1'b1, 32'h4, 32'hA0A0_0004, 0, 1'b0, a1);
    txn(1'b1, 32'h3FC, 32'hA0A0_03FC, 0, 1'b0, a2);
    chk("spacing_w0_a", a1 - a0, 2);
    chk("spacing_w0_b", a2 - a1, 2);
    txn(1'b0, 32'h0, 32'h0, 0, 1'b0, a0);
    txn(1'b0, 32'h4, 32'h0, 0, 1'b0, a1);
    txn(1'b0, 32'h3FC, 32'h0, 0, 1'b0, a2);
    chk("spacing_w0_c", a1 - a0, 2);
    chk("spacing_w0_d", a2 - a1, 2);
    txn(1'b0, 32'h400, 32'h0, 0, 1'b0, acc);

    // Randomized traffic against the model, both configurations
    for (int s = 0; s < 2; s++) begin
      use0 = (s == 1);
      for (int i = 0; i < 12; i++) txn(1'b1, widx[i] * 4, $urandom, 0, 1'b0, acc);
      for (int t = 0; t < 40; t++) begin
        int r;
        r = $urandom_range(0, 9);
        if (r <= 6)      a = widx[$urandom_range(0, 11)] * 4;
        else if (r == 7) a = widx[$urandom_range(0, 11)] * 4 + $urandom_range(1, 3);
        else if (r == 8) a = $urandom_range(256, 1023) * 4;
        else             a = 32'hFFFF_FFFC;
        txn(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3), 1'b0, acc);
      end
    end

    // Reset during the wait states of a store
    use0 = 1'b0;
    txn(1'b1, 32'h20, 32'h0, 0, 1'b0, acc);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("busy_before_rst", {31'd0, o_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_req_ready", {31'd0, o_req_ready}, 32'd1);
    chk("midrst_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    chk("midrst_busy", {31'd0, o_busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    txn(1'b0, 32'h20, 32'h0, 0, 1'b0, acc);
    txn(1'b0, 32'h10, 32'h0, 0, 1'b0, acc);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
